fetch_issue_ooo: RTL and testbench

Front-end PC generator for the out-of-order core. Holds the fetch PC, issues one instruction-cache request per cycle, and forwards the same PC to the fetch-receive stage. A small direct-mapped next-line predictor (NLP/BTB) picks the next PC. Backend updates redirect the PC and train the BTB.

---
 rtl/fetch_issue_ooo.sv | 128 ++++++++++++
 tb/tb_fetch_issue_ooo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_ooo.sv
// fetch_issue_ooo: front-end PC generator for the out-of-order core.
// Holds the fetch PC, issues one I-cache request per cycle and forwards the
// same PC to fetch-receive. A 16-entry direct-mapped, tagless next-line
// predictor (BTB) supplies the next PC on a hit. Backend update packets
// can redirect the PC, train the BTB, do both, or do neither.
//
// Ports:
//   clock, reset             - single clock, synchronous active-high reset
//   fetch_request_ready      - I-cache can accept a request
//   fetch_request_valid/PC   - I-cache request
//   fetch_issue_ready        - fetch-receive has a free slot
//   fetch_issue_valid/PC     - request actually sent, PC forwarded to FR
//   fetch_issue_NLP_BTB_hit  - BTB entry for the current PC is valid
//   fetch_update_valid/ready - backend update handshake
//   fetch_update_data        - {idx[4], btb_valid, btb_we, redirect, target}
module fetch_issue_ooo #(
    parameter int XLEN       = 64,
    parameter int NLP_UPDATE = 71
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_request_ready,
    output logic                  fetch_request_valid,
    output logic [XLEN-1:0]       fetch_request_PC,
    output logic                  fetch_issue_valid,
    input  logic                  fetch_issue_ready,
    output logic [XLEN-1:0]       fetch_issue_PC,
    output logic                  fetch_issue_NLP_BTB_hit,
    input  logic                  fetch_update_valid,
    output logic                  fetch_update_ready,
    input  logic [NLP_UPDATE-1:0] fetch_update_data
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_r;
    logic [15:0]     btb_valid_r;
    logic [XLEN-1:0] btb_target_r [16];

    logic            redirect_now_s;
    logic            btb_we_s;
    logic            btb_wr_valid_s;
    logic [3:0]      btb_wr_idx_s;
    logic [XLEN-1:0] upd_target_s;
    logic [3:0]      btb_rd_idx_s;
    logic            btb_hit_s;
    logic [XLEN-1:0] btb_rd_target_s;
    logic            req_valid_s;
    logic            issue_valid_s;
    logic [XLEN-1:0] pc_next_s;

    // Decode the update packet fields.
    always_comb begin
        upd_target_s   = fetch_update_data[XLEN-1:0];
        redirect_now_s = fetch_update_valid & fetch_update_data[XLEN];
        btb_we_s       = fetch_update_valid & fetch_update_data[XLEN+1];
        btb_wr_valid_s = fetch_update_data[XLEN+2];
        btb_wr_idx_s   = fetch_update_data[XLEN+6:XLEN+3];
    end

    // BTB lookup on the current PC; reads registered state, so a same-cycle
    // write to this index is only seen from the next cycle.
    always_comb begin
        btb_rd_idx_s    = pc_r[5:2];
        btb_hit_s       = btb_valid_r[btb_rd_idx_s];
        btb_rd_target_s = btb_target_r[btb_rd_idx_s];
    end

    // Request/issue handshakes; a redirect squashes the request this cycle.
    always_comb begin
        req_valid_s   = ~reset & fetch_issue_ready & ~redirect_now_s;
        issue_valid_s = req_valid_s & fetch_request_ready;
    end

    // Next-PC selection: redirect beats issue; otherwise hold.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect_now_s) begin
            pc_next_s = upd_target_s;
        end else if (issue_valid_s) begin
            if (btb_hit_s) begin
                pc_next_s = btb_rd_target_s;
            end else begin
                pc_next_s = pc_r + PC_STEP;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register; reset overrides any update or issue in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r <= '0;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // BTB valid bits: cleared by reset, trained by update packets.
    always_ff @(posedge clock) begin
        if (reset) begin
            btb_valid_r <= 16'h0000;
        end else if (btb_we_s) begin
            btb_valid_r[btb_wr_idx_s] <= btb_wr_valid_s;
        end else begin
            btb_valid_r <= btb_valid_r;
        end
    end

    // BTB targets: no reset needed since they are qualified by valid bits.
    always_ff @(posedge clock) begin
        if (!reset && btb_we_s) begin
            btb_target_r[btb_wr_idx_s] <= upd_target_s;
        end
    end

    // Output mapping.
    always_comb begin
        fetch_request_valid     = req_valid_s;
        fetch_issue_valid       = issue_valid_s;
        fetch_request_PC        = pc_r;
        fetch_issue_PC          = pc_r;
        fetch_issue_NLP_BTB_hit = btb_hit_s;
        fetch_update_ready      = ~reset;
    end

endmodule

// File: tb/tb_fetch_issue_ooo.sv
// Directed testbench for fetch_issue_ooo: sequential PC stepping, stalls,
// redirects, BTB training/hits, same-cycle BTB read/write, wrap-around and
// reset asserted mid-stream.
module tb_fetch_issue_ooo;

    localparam int XLEN = 64;
    localparam int NLP_UPDATE = 71;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  fetch_request_ready;
    logic                  fetch_request_valid;
    logic [XLEN-1:0]       fetch_request_PC;
    logic                  fetch_issue_valid;
    logic                  fetch_issue_ready;
    logic [XLEN-1:0]       fetch_issue_PC;
    logic                  fetch_issue_NLP_BTB_hit;
    logic                  fetch_update_valid;
    logic                  fetch_update_ready;
    logic [NLP_UPDATE-1:0] fetch_update_data;

    int checks = 0;
    int errors = 0;

    fetch_issue_ooo #(.XLEN(XLEN), .NLP_UPDATE(NLP_UPDATE)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .fetch_request_ready     (fetch_request_ready),
        .fetch_request_valid     (fetch_request_valid),
        .fetch_request_PC        (fetch_request_PC),
        .fetch_issue_valid       (fetch_issue_valid),
        .fetch_issue_ready       (fetch_issue_ready),
        .fetch_issue_PC          (fetch_issue_PC),
        .fetch_issue_NLP_BTB_hit (fetch_issue_NLP_BTB_hit),
        .fetch_update_valid      (fetch_update_valid),
        .fetch_update_ready      (fetch_update_ready),
        .fetch_update_data       (fetch_update_data)
    );

    always #5 clock = ~clock;

    // Advance one cycle, then step off the edge before driving/sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Build an update packet {idx, btb_valid, btb_we, redirect, target}.
    function automatic logic [NLP_UPDATE-1:0] pkt(input logic [3:0] idx, input logic bv,
                                                  input logic we, input logic rd,
                                                  input logic [XLEN-1:0] tgt);
        return {idx, bv, we, rd, tgt};
    endfunction

    task automatic test_reset();
        reset = 1'b1; fetch_request_ready = 1'b1; fetch_issue_ready = 1'b1;
        fetch_update_valid = 1'b0; fetch_update_data = '0;
        tick(); tick();
        checks++; if (fetch_request_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", fetch_request_valid); end
        checks++; if (fetch_issue_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid got %b exp 0", fetch_issue_valid); end
        checks++; if (fetch_update_ready !== 1'b0) begin errors++; $display("FAIL rst_upd_ready got %b exp 0", fetch_update_ready); end
        checks++; if (fetch_request_PC !== 64'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", fetch_request_PC); end
        checks++; if (fetch_issue_PC !== 64'h0) begin errors++; $display("FAIL rst_issue_pc got %h exp 0", fetch_issue_PC); end
        checks++; if (fetch_issue_NLP_BTB_hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b exp 0", fetch_issue_NLP_BTB_hit); end
        reset = 1'b0;
        #1;
        checks++; if (fetch_request_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b exp 1", fetch_request_valid); end
        checks++; if (fetch_issue_valid !== 1'b1) begin errors++; $display("FAIL first_issue_valid got %b exp 1", fetch_issue_valid); end
        checks++; if (fetch_update_ready !== 1'b1) begin errors++; $display("FAIL first_upd_ready got %b exp 1", fetch_update_ready); end
        checks++; if (fetch_request_PC !== 64'h0) begin errors++; $display("FAIL first_pc got %h exp 0", fetch_request_PC); end
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (fetch_request_PC !== 64'h4) begin errors++; $display("FAIL seq_pc4 got %h exp 4", fetch_request_PC); end
        tick();
        checks++; if (fetch_request_PC !== 64'h8) begin errors++; $display("FAIL seq_pc8 got %h exp 8", fetch_request_PC); end
        checks++; if (fetch_issue_PC !== 64'h8) begin errors++; $display("FAIL seq_issue_pc8 got %h exp 8", fetch_issue_PC); end
    endtask

    task automatic test_stall();
        fetch_request_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (fetch_issue_valid !== 1'b0) begin errors++; $display("FAIL stall_issue_valid[%0d] got %b exp 0", i, fetch_issue_valid); end
            checks++; if (fetch_request_PC !== 64'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 8", i, fetch_request_PC); end
            tick();
        end
        fetch_request_ready = 1'b1;
        #1;
        checks++; if (fetch_request_PC !== 64'h8) begin errors++; $display("FAIL stall_release_pc got %h exp 8", fetch_request_PC); end
        checks++; if (fetch_issue_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid got %b exp 1", fetch_issue_valid); end
        tick();
        checks++; if (fetch_request_PC !== 64'hC) begin errors++; $display("FAIL stall_next_pc got %h exp c", fetch_request_PC); end
        // FR not ready: request itself drops, PC holds.
        fetch_issue_ready = 1'b0;
        #1;
        checks++; if (fetch_request_valid !== 1'b0) begin errors++; $display("FAIL fr_stall_req_valid got %b exp 0", fetch_request_valid); end
        tick();
        checks++; if (fetch_request_PC !== 64'hC) begin errors++; $display("FAIL fr_stall_pc got %h exp c", fetch_request_PC); end
        fetch_issue_ready = 1'b1;
    endtask

    task automatic test_redirect();
        fetch_update_valid = 1'b1;
        fetch_update_data = pkt(4'd0, 1'b0, 1'b0, 1'b1, 64'h100);
        #1;
        checks++; if (fetch_request_valid !== 1'b0) begin errors++; $display("FAIL redir_squash got %b exp 0", fetch_request_valid); end
        checks++; if (fetch_issue_valid !== 1'b0) begin errors++; $display("FAIL redir_issue got %b exp 0", fetch_issue_valid); end
        tick();
        fetch_update_valid = 1'b0;
        #1;
        checks++; if (fetch_request_PC !== 64'h100) begin errors++; $display("FAIL redir_pc got %h exp 100", fetch_request_PC); end
        tick();
        checks++; if (fetch_request_PC !== 64'h104) begin errors++; $display("FAIL redir_pc_next got %h exp 104", fetch_request_PC); end
        // Packet with no flags: accepted, no effect.
        fetch_update_valid = 1'b1;
        fetch_update_data = pkt(4'd0, 1'b0, 1'b0, 1'b0, 64'd100);
        #1;
        checks++; if (fetch_request_valid !== 1'b1) begin errors++; $display("FAIL noflag_req_valid got %b exp 1", fetch_request_valid); end
        tick();
        fetch_update_valid = 1'b0;
        #1;
        checks++; if (fetch_request_PC !== 64'h108) begin errors++; $display("FAIL noflag_pc got %h exp 108", fetch_request_PC); end
    endtask

    task automatic test_btb();
        // Train idx 1 (PC 0x104) -> 0x200 while fetching 0x108 (idx 2).
        fetch_update_valid = 1'b1;
        fetch_update_data = pkt(4'd1, 1'b1, 1'b1, 1'b0, 64'h200);
        #1;
        checks++; if (fetch_issue_NLP_BTB_hit !== 1'b0) begin errors++; $display("FAIL btb_miss_108 got %b exp 0", fetch_issue_NLP_BTB_hit); end
        tick();
        fetch_update_data = pkt(4'd0, 1'b0, 1'b0, 1'b1, 64'h104);
        tick();
        // At 0x104: hit. Same-cycle invalidating write must not affect lookup.
        fetch_update_data = pkt(4'd1, 1'b0, 1'b1, 1'b0, 64'h0);
        #1;
        checks++; if (fetch_request_PC !== 64'h104) begin errors++; $display("FAIL btb_pc_104 got %h exp 104", fetch_request_PC); end
        checks++; if (fetch_issue_NLP_BTB_hit !== 1'b1) begin errors++; $display("FAIL btb_hit_104 got %b exp 1", fetch_issue_NLP_BTB_hit); end
        tick();
        fetch_update_valid = 1'b0;
        #1;
        checks++; if (fetch_request_PC !== 64'h200) begin errors++; $display("FAIL btb_target got %h exp 200", fetch_request_PC); end
        checks++; if (fetch_issue_NLP_BTB_hit !== 1'b0) begin errors++; $display("FAIL btb_miss_200 got %b exp 0", fetch_issue_NLP_BTB_hit); end
        // Return to 0x104: entry now invalid, sequential fetch.
        fetch_update_valid = 1'b1;
        fetch_update_data = pkt(4'd0, 1'b0, 1'b0, 1'b1, 64'h104);
        tick();
        fetch_update_valid = 1'b0;
        #1;
        checks++; if (fetch_issue_NLP_BTB_hit !== 1'b0) begin errors++; $display("FAIL btb_inval_hit got %b exp 0", fetch_issue_NLP_BTB_hit); end
        tick();
        checks++; if (fetch_request_PC !== 64'h108) begin errors++; $display("FAIL btb_inval_pc got %h exp 108", fetch_request_PC); end
    endtask

    task automatic test_wrap();
        fetch_update_valid = 1'b1;
        fetch_update_data = pkt(4'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        fetch_update_valid = 1'b0;
        #1;
        checks++; if (fetch_request_PC !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp fffffffffffffffc", fetch_request_PC); end
        checks++; if (fetch_issue_valid !== 1'b1) begin errors++; $display("FAIL wrap_issue got %b exp 1", fetch_issue_valid); end
        tick();
        checks++; if (fetch_request_PC !== 64'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", fetch_request_PC); end
    endtask

    task automatic test_reset_midstream();
        // Train idx 0 -> 0x300, then redirect to 0x40 (idx 0) to confirm a hit.
        fetch_update_valid = 1'b1;
        fetch_update_data = pkt(4'd0, 1'b1, 1'b1, 1'b0, 64'h300);
        tick();
        checks++; if (fetch_request_PC !== 64'h4) begin errors++; $display("FAIL same_cycle_pc got %h exp 4", fetch_request_PC); end
        fetch_update_data = pkt(4'd0, 1'b0, 1'b0, 1'b1, 64'h40);
        tick();
        fetch_update_valid = 1'b0;
        #1;
        checks++; if (fetch_issue_NLP_BTB_hit !== 1'b1) begin errors++; $display("FAIL mid_hit_40 got %b exp 1", fetch_issue_NLP_BTB_hit); end
        // Reset together with a redirect: reset wins and clears the BTB.
        reset = 1'b1;
        fetch_update_valid = 1'b1;
        fetch_update_data = pkt(4'd0, 1'b1, 1'b1, 1'b1, 64'h500);
        tick();
        fetch_update_valid = 1'b0;
        #1;
        checks++; if (fetch_request_PC !== 64'h0) begin errors++; $display("FAIL mid_rst_pc got %h exp 0", fetch_request_PC); end
        checks++; if (fetch_request_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b exp 0", fetch_request_valid); end
        reset = 1'b0;
        #1;
        checks++; if (fetch_issue_NLP_BTB_hit !== 1'b0) begin errors++; $display("FAIL mid_rst_hit got %b exp 0", fetch_issue_NLP_BTB_hit); end
        tick();
        checks++; if (fetch_request_PC !== 64'h4) begin errors++; $display("FAIL mid_rst_next got %h exp 4", fetch_request_PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_btb();
        test_wrap();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
